// File: rtl/mbus_wakeup_ctrl_if.sv
// Swapper, bus-controller and power-domain signals of mbus_wakeup_ctrl.
// MBUS_WAKEUP_COUNT_EN adds the wake counter clear/value signals.
interface mbus_wakeup_ctrl_if;
    logic       INT_FLAG;
    logic       LAST_CLK;
    logic       SLEEP_REQ;
    logic       INT_FLAG_RESETn;
    logic       SLEEP;
    logic       ISOLATE;
    logic       LAYER_RESETn;
    logic       CLK_GATE;
    logic       WAKEUP;
    logic       WAKE_LAST_CLK;
    logic       BUSY;
`ifdef MBUS_WAKEUP_COUNT_EN
    logic       WAKE_CNT_CLR;
    logic [7:0] WAKE_CNT;

    modport master (
        input  INT_FLAG, LAST_CLK, SLEEP_REQ, WAKE_CNT_CLR,
        output INT_FLAG_RESETn, SLEEP, ISOLATE, LAYER_RESETn, CLK_GATE,
               WAKEUP, WAKE_LAST_CLK, BUSY, WAKE_CNT
    );
    modport slave (
        output INT_FLAG, LAST_CLK, SLEEP_REQ, WAKE_CNT_CLR,
        input  INT_FLAG_RESETn, SLEEP, ISOLATE, LAYER_RESETn, CLK_GATE,
               WAKEUP, WAKE_LAST_CLK, BUSY, WAKE_CNT
    );
`else
    modport master (
        input  INT_FLAG, LAST_CLK, SLEEP_REQ,
        output INT_FLAG_RESETn, SLEEP, ISOLATE, LAYER_RESETn, CLK_GATE,
               WAKEUP, WAKE_LAST_CLK, BUSY
    );
    modport slave (
        output INT_FLAG, LAST_CLK, SLEEP_REQ,
        input  INT_FLAG_RESETn, SLEEP, ISOLATE, LAYER_RESETn, CLK_GATE,
               WAKEUP, WAKE_LAST_CLK, BUSY
    );
`endif
endinterface

// File: rtl/mbus_wakeup_ctrl.sv
// MBus wakeup controller: synchronises the swapper interrupt, clears it, and sequences layer power.
// Optional wake counter enabled by defining MBUS_WAKEUP_COUNT_EN.
module mbus_wakeup_ctrl #(
    parameter int STEP_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic              CLK,
    input  logic              RESETn,
    mbus_wakeup_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_ASLEEP, S_PWR_ON, S_REL_RST, S_REL_CLK, S_REL_ISO,
        S_AWAKE, S_GATE_ISO, S_GATE_CLK, S_HOLD_RST, S_PWR_OFF
    } state_t;

    localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(STEP_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1, r_int_s, r_flag_rstn, r_pending, r_last;
    logic             r_sleep, r_iso, r_lrstn, r_cgate, r_wakeup, r_busy;
    logic             w_accept, w_step_done, w_wake_entry, w_pend_clear;

    // An accepted interrupt is the first synchronised-high cycle while the clear is released.
    assign w_accept     = r_int_s & r_flag_rstn;
    assign w_step_done  = (r_cnt == '0);
    assign w_wake_entry = (r_state == S_REL_ISO) && w_step_done;
    assign w_pend_clear = ((r_state == S_ASLEEP) && r_pending) || w_wake_entry;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sync1     <= 1'b0;
            r_int_s     <= 1'b0;
            r_flag_rstn <= 1'b1;
            r_last      <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_sync1 <= bus.INT_FLAG;
            r_int_s <= r_sync1;
            if (w_accept)
                r_flag_rstn <= 1'b0;
            else if (!r_flag_rstn && !r_int_s)
                r_flag_rstn <= 1'b1;
            if (w_accept)
                r_last <= bus.LAST_CLK;
            // A wake already under way absorbs any interrupt that arrived during it.
            if (w_pend_clear)
                r_pending <= 1'b0;
            else if (w_accept && (r_state != S_AWAKE))
                r_pending <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= S_ASLEEP;
            r_cnt    <= '0;
            r_sleep  <= 1'b1;
            r_iso    <= 1'b1;
            r_lrstn  <= 1'b0;
            r_cgate  <= 1'b1;
            r_wakeup <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_wakeup <= 1'b0;
            if (!w_step_done)
                r_cnt <= r_cnt - CNT_W'(1);
            case (r_state)
                S_ASLEEP: if (r_pending) begin
                    r_state <= S_PWR_ON;  r_sleep <= 1'b0; r_busy <= 1'b1; r_cnt <= LP_LOAD;
                end
                S_PWR_ON: if (w_step_done) begin
                    r_state <= S_REL_RST; r_lrstn <= 1'b1; r_cnt <= LP_LOAD;
                end
                S_REL_RST: if (w_step_done) begin
                    r_state <= S_REL_CLK; r_cgate <= 1'b0; r_cnt <= LP_LOAD;
                end
                S_REL_CLK: if (w_step_done) begin
                    r_state <= S_REL_ISO; r_iso <= 1'b0; r_cnt <= LP_LOAD;
                end
                S_REL_ISO: if (w_step_done) begin
                    r_state <= S_AWAKE;   r_wakeup <= 1'b1; r_busy <= 1'b0;
                end
                S_AWAKE: if (bus.SLEEP_REQ) begin
                    r_state <= S_GATE_ISO; r_iso <= 1'b1; r_busy <= 1'b1; r_cnt <= LP_LOAD;
                end
                S_GATE_ISO: if (w_step_done) begin
                    r_state <= S_GATE_CLK; r_cgate <= 1'b1; r_cnt <= LP_LOAD;
                end
                S_GATE_CLK: if (w_step_done) begin
                    r_state <= S_HOLD_RST; r_lrstn <= 1'b0; r_cnt <= LP_LOAD;
                end
                S_HOLD_RST: if (w_step_done) begin
                    r_state <= S_PWR_OFF;  r_sleep <= 1'b1; r_cnt <= LP_LOAD;
                end
                S_PWR_OFF: if (w_step_done) begin
                    r_state <= S_ASLEEP;   r_busy <= 1'b0;
                end
                default: r_state <= S_ASLEEP;
            endcase
        end
    end

    assign bus.INT_FLAG_RESETn = r_flag_rstn;
    assign bus.SLEEP           = r_sleep;
    assign bus.ISOLATE         = r_iso;
    assign bus.LAYER_RESETn    = r_lrstn;
    assign bus.CLK_GATE        = r_cgate;
    assign bus.WAKEUP          = r_wakeup;
    assign bus.WAKE_LAST_CLK   = r_last;
    assign bus.BUSY            = r_busy;

`ifdef MBUS_WAKEUP_COUNT_EN
    logic [7:0] r_wake_cnt;

    // Clear wins over a simultaneous wake; the count sticks at 255.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            r_wake_cnt <= 8'd0;
        else if (bus.WAKE_CNT_CLR)
            r_wake_cnt <= 8'd0;
        else if (w_wake_entry && (r_wake_cnt != 8'hFF))
            r_wake_cnt <= r_wake_cnt + 8'd1;
    end

    assign bus.WAKE_CNT = r_wake_cnt;
`endif
endmodule

// File: tb/tb_mbus_wakeup_ctrl.sv
// Self-checking bench for mbus_wakeup_ctrl: directed power sequences then random traffic,
// every cycle compared with a phase-table reference model.
`timescale 1ns/1ps
module tb_mbus_wakeup_ctrl;
    localparam int STEP = 4;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    mbus_wakeup_ctrl_if ifc();

    mbus_wakeup_ctrl #(.STEP_CYCLES(STEP), .CNT_W(3)) dut (
        .CLK    (clk),
        .RESETn (rstN),
        .bus    (ifc)
    );

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycleNo       = 0;
    int wakeCount     = 0;
    int asleepCycles  = 0;
    int edgeAt [8];
    logic [7:0] prevVec;

    // Reference model: phase 0..9 walks ASLEEP, four release steps, AWAKE, four gating steps.
    int mPhase, mTimer;
    bit mPend, mRstn, mSync1, mInts, mLast, mWake;

    localparam logic [7:0] RESET_VEC = 8'b1101_0001;

    function automatic logic [7:0] dutVec();
        return {ifc.SLEEP, ifc.ISOLATE, ifc.LAYER_RESETn, ifc.CLK_GATE,
                ifc.WAKEUP, ifc.WAKE_LAST_CLK, ifc.BUSY, ifc.INT_FLAG_RESETn};
    endfunction

    function automatic logic [7:0] modelVec();
        logic s, i, r, c, b;
        s = !(mPhase >= 1 && mPhase <= 8);
        r =  (mPhase >= 2 && mPhase <= 7);
        c = !(mPhase >= 3 && mPhase <= 6);
        i = !(mPhase >= 4 && mPhase <= 5);
        b =  (mPhase != 0 && mPhase != 5);
        return {s, i, r, c, mWake, mLast, b, mRstn};
    endfunction

    task automatic modelReset();
        mPhase = 0; mTimer = 0; mPend = 0; mRstn = 1;
        mSync1 = 0; mInts = 0; mLast = 0; mWake = 0;
    endtask

    task automatic modelStep();
        bit acc;
        int np;
        acc = mInts && mRstn;
        np  = mPhase;
        if (mPhase == 0) begin
            if (mPend) np = 1;
        end else if (mPhase == 5) begin
            if (ifc.SLEEP_REQ) np = 6;
        end else if (mTimer == 0) begin
            np = (mPhase + 1) % 10;
        end
        if (np != mPhase) mTimer = STEP - 1;
        else if (mTimer > 0) mTimer--;
        mWake = (np == 5) && (mPhase != 5);
        if ((mPhase == 0 && mPend) || mWake) mPend = 0;
        else if (acc && mPhase != 5) mPend = 1;
        if (acc) mLast = ifc.LAST_CLK;
        if (acc) mRstn = 0;
        else if (!mRstn && !mInts) mRstn = 1;
        mInts  = mSync1;
        mSync1 = ifc.INT_FLAG;
        mPhase = np;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            mismatchCount++;
            $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cycleNo, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, then drive the swapper and bus-controller inputs.
    task automatic applyStimulus(input bit sreq, input bit irq, input bit lclk);
        logic [7:0] v;
        @(negedge clk);
        cycleNo++;
        v = dutVec();
        checkOutput("outs", 32'(v), 32'(modelVec()));
        for (int b = 0; b < 8; b++)
            if (v[b] !== prevVec[b]) edgeAt[b] = cycleNo;
        prevVec = v;
        if (ifc.WAKEUP) wakeCount++;
        if (ifc.SLEEP && !ifc.BUSY) asleepCycles++;
        if (!mRstn) ifc.INT_FLAG = 1'b0;
        if (!ifc.INT_FLAG) ifc.LAST_CLK = lclk;
        if (irq && mRstn) ifc.INT_FLAG = 1'b1;
        ifc.SLEEP_REQ = sreq;
        modelStep();
    endtask

    task automatic runToPhase(input string tag, input int phase, input int bound);
        for (int i = 0; i < bound && mPhase != phase; i++)
            applyStimulus(1'b0, 1'b0, ifc.LAST_CLK);
        checkOutput(tag, 32'(mPhase), 32'(phase));
    endtask

    task automatic clearEdges();
        for (int b = 0; b < 8; b++) edgeAt[b] = -1000;
    endtask

    initial begin
        int n;
        ifc.INT_FLAG  = 1'b0;
        ifc.LAST_CLK  = 1'b0;
        ifc.SLEEP_REQ = 1'b0;
`ifdef MBUS_WAKEUP_COUNT_EN
        ifc.WAKE_CNT_CLR = 1'b0;
`endif
        modelReset();
        clearEdges();
        #23;
        checkOutput("resetVec", 32'(dutVec()), 32'(RESET_VEC));
        prevVec = dutVec();
        @(negedge clk);
        rstN = 1'b1;

        // Idle after reset
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idleVec", 32'(dutVec()), 32'(RESET_VEC));

        // Wake from ASLEEP with LAST_CLK=1
        wakeCount = 0;
        clearEdges();
        applyStimulus(1'b0, 1'b1, 1'b1);
        n = 0;
        for (int i = 0; i < 8 && ifc.INT_FLAG_RESETn; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("ackWithin3", 32'(n <= 3 && !ifc.INT_FLAG_RESETn), 32'd1);
        runToPhase("reachAwake1", 5, 40);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("awakeVec1", 32'(dutVec()), 32'(8'b0010_0101));
        checkOutput("wakePulses1", 32'(wakeCount), 32'd1);
        checkOutput("wakeSpan", 32'(edgeAt[6] - edgeAt[7]), 32'(3 * STEP));

        // Sleep-down order and spacing
        clearEdges();
        applyStimulus(1'b1, 1'b0, 1'b1);
        runToPhase("reachAsleep1", 0, 40);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("isoToGate", 32'(edgeAt[4] - edgeAt[6]), 32'(STEP));
        checkOutput("gateToRst", 32'(edgeAt[5] - edgeAt[4]), 32'(STEP));
        checkOutput("rstToPwr",  32'(edgeAt[7] - edgeAt[5]), 32'(STEP));
        checkOutput("sleepSpan", 32'(edgeAt[1] - edgeAt[6]), 32'(4 * STEP));

        // Interrupt during GATE_CLK: complete sleep, one ASLEEP cycle, wake again
        applyStimulus(1'b0, 1'b1, 1'b0);
        runToPhase("reachAwake2", 5, 40);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runToPhase("reachGateClk", 7, 20);
        wakeCount = 0;
        asleepCycles = 0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        runToPhase("reachAwake3", 5, 80);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wakePulses2", 32'(wakeCount), 32'd1);
        checkOutput("asleepOneCycle", 32'(asleepCycles), 32'd1);
        checkOutput("awakeVec2", 32'(dutVec()), 32'(8'b0010_0001));

        // Interrupt while AWAKE is cleared and discarded
        wakeCount = 0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("wakePulses3", 32'(wakeCount), 32'd0);
        checkOutput("awakeVec3", 32'(dutVec()), 32'(8'b0010_0101));
        applyStimulus(1'b1, 1'b0, 1'b1);
        runToPhase("reachAsleep2", 0, 40);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("staysAsleep", 32'(dutVec()), 32'(8'b1101_0101));

        // Asynchronous reset in the middle of REL_CLK
        applyStimulus(1'b0, 1'b1, 1'b0);
        runToPhase("reachRelClk", 3, 40);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1 checkOutput("midReset", 32'(dutVec()), 32'(RESET_VEC));
        ifc.INT_FLAG = 1'b0;
        modelReset();
        prevVec = dutVec();
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef MBUS_WAKEUP_COUNT_EN
        // Wake counter saturation and clear
        for (int w = 0; w < 256; w++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            runToPhase("cntWake", 5, 40);
            applyStimulus(1'b1, 1'b0, 1'b0);
            runToPhase("cntSleep", 0, 40);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wakeCntSat", 32'(ifc.WAKE_CNT), 32'd255);
        ifc.WAKE_CNT_CLR = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        ifc.WAKE_CNT_CLR = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wakeCntClr", 32'(ifc.WAKE_CNT), 32'd0);
`endif

        // Random interrupts, LAST_CLK values and sleep requests
        for (int i = 0; i < 1500; i++)
            applyStimulus(($urandom % 16) == 0, ($urandom % 12) == 0, 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
